// File: rtl/image_resize_pkg.sv
// Shared widths, timing constants and the FSM state type for the resize output framer.
package image_resize_pkg;

    localparam int PIX_W      = 24;
    localparam int W_W        = 12;
    localparam int H_W        = 11;
    localparam int OW_W       = 16;
    localparam int OH_W       = 15;
    localparam int DIV_CYCLES = 12;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN,
        DONE
    } framer_state_e;

    // A scale factor of zero behaves as a factor of one.
    function automatic logic [3:0] eff_factor(input logic [3:0] f);
        return (f == 4'd0) ? 4'd1 : f;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: RAM with registered read plus an output register
// that is loaded straight from the write port when the RAM is empty.
module sync_fifo_fwft #(
    parameter int DATA_W = 24,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    input  logic              rd_en,
    output logic              empty,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       level
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       mem_cnt_q;
    logic [AW:0]       level_q;
    logic [DATA_W-1:0] dout_q;
    logic              dval_q;

    logic wr_ok;
    logic pop;
    logic load;
    logic mem_has;
    logic mem_rd;
    logic mem_wr;
    logic bypass;

    assign full    = (level_q == FULL_LVL);
    assign empty   = !dval_q;
    assign dout    = dout_q;
    assign level   = level_q;

    // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign pop     = rd_en && dval_q;
    assign load    = !dval_q || pop;
    assign mem_has = (mem_cnt_q != '0);
    assign mem_rd  = load && mem_has;
    assign bypass  = load && !mem_has && wr_ok;
    assign mem_wr  = wr_ok && !bypass;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            level_q   <= '0;
            dout_q    <= '0;
            dval_q    <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (mem_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                dout_q   <= mem[rd_ptr_q];
                dval_q   <= 1'b1;
            end else if (bypass) begin
                dout_q   <= din;
                dval_q   <= 1'b1;
            end else if (load) begin
                dval_q   <= 1'b0;
            end
            mem_cnt_q <= mem_cnt_q + {{AW{1'b0}}, mem_wr} - {{AW{1'b0}}, mem_rd};
            level_q   <= level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/image_resize_out_framer.sv
// Buffers the resize core's pixel stream and re-emits it as AXI4-Stream video with SOF/EOL.
// Optional statistics outputs are built when RESIZE_FRAMER_STATS_EN is defined.
module image_resize_out_framer
    import image_resize_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int FIFO_AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        img_width,
    input  logic [10:0]        img_height,
    input  logic               up_flag,
    input  logic [3:0]         x_scale_factor,
    input  logic [3:0]         y_scale_factor,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               m_tuser,
    output logic               m_tlast,
    output logic               frame_done,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
`ifdef RESIZE_FRAMER_STATS_EN
    ,
    output logic [15:0]        frame_count,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int         NDIV      = 2;
    localparam logic [3:0] CALC_LAST = 4'(DIV_CYCLES - 1);

    framer_state_e  state_q;
    logic [W_W-1:0] w_q;
    logic [H_W-1:0] h_q;
    logic           up_q;
    logic [3:0]     xs_q;
    logic [3:0]     ys_q;
    logic [3:0]     calc_cnt_q;
    logic [OW_W-1:0] col_q;
    logic [OH_W-1:0] row_q;
    logic           frame_done_q;
    logic           overflow_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;

    logic            start;
    logic            beat;
    logic            last_col;
    logic            last_row;
    logic            frame_end;
    logic [OW_W-1:0] out_w;
    logic [OH_W-1:0] out_h;

    logic [W_W-1:0] div_num [NDIV];
    logic [3:0]     div_den [NDIV];
    logic [W_W-1:0] div_quo [NDIV];

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (valid_i),
        .din    (data_i),
        .full   (fifo_full),
        .rd_en  (fifo_rd),
        .empty  (fifo_empty),
        .dout   (fifo_dout),
        .level  (fifo_level)
    );

    assign start     = (state_q == IDLE) && valid_i;
    assign m_tvalid  = (state_q == RUN) && !fifo_empty;
    assign beat      = m_tvalid && m_tready;
    assign fifo_rd   = beat;
    assign last_col  = (col_q == out_w - 16'd1);
    assign last_row  = (row_q == out_h - 15'd1);
    assign frame_end = beat && last_col && last_row;
    assign m_tdata   = fifo_dout;
    assign m_tuser   = m_tvalid && (col_q == '0) && (row_q == '0);
    assign m_tlast   = m_tvalid && last_col;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // Dividends come from the live inputs because they are captured on the same edge as the config.
    assign div_num[0] = img_width - 12'd1;
    assign div_num[1] = {1'b0, img_height} - 12'd1;
    assign div_den[0] = xs_q;
    assign div_den[1] = ys_q;

    genvar gi;
    generate
        for (gi = 0; gi < NDIV; gi++) begin : g_div
            logic [4:0]     rem_q;
            logic [W_W-1:0] quo_q;
            logic [4:0]     trial;

            assign trial       = {rem_q[3:0], quo_q[W_W-1]};
            assign div_quo[gi] = quo_q;

            // One quotient bit per CALC cycle, MSB first.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rem_q <= '0;
                    quo_q <= '0;
                end else if (start) begin
                    rem_q <= '0;
                    quo_q <= div_num[gi];
                end else if (state_q == CALC) begin
                    if (trial >= {1'b0, div_den[gi]}) begin
                        rem_q <= trial - {1'b0, div_den[gi]};
                        quo_q <= {quo_q[W_W-2:0], 1'b1};
                    end else begin
                        rem_q <= trial;
                        quo_q <= {quo_q[W_W-2:0], 1'b0};
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        if (up_q) begin
            out_w = OW_W'(w_q) * OW_W'(xs_q);
            out_h = OH_W'(h_q) * OH_W'(ys_q);
        end else begin
            out_w = OW_W'(div_quo[0]) + 16'd1;
            out_h = OH_W'(div_quo[1]) + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            up_q         <= 1'b0;
            xs_q         <= 4'd1;
            ys_q         <= 4'd1;
            calc_cnt_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        w_q        <= img_width;
                        h_q        <= img_height;
                        up_q       <= up_flag;
                        xs_q       <= eff_factor(x_scale_factor);
                        ys_q       <= eff_factor(y_scale_factor);
                        calc_cnt_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (calc_cnt_q == CALC_LAST) begin
                        state_q <= RUN;
                    end else begin
                        calc_cnt_q <= calc_cnt_q + 4'd1;
                    end
                end
                RUN: begin
                    if (frame_end) begin
                        col_q        <= '0;
                        row_q        <= '0;
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else if (beat) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 15'd1;
                        end else begin
                            col_q <= col_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (valid_i && fifo_full && !fifo_rd) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef RESIZE_FRAMER_STATS_EN
    logic [15:0] frame_count_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (frame_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (start) begin
                stall_cycles_q <= '0;
            end else if (m_tvalid && !m_tready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign frame_count  = frame_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_image_resize_out_framer.sv
// Randomized bench for image_resize_out_framer against a queue-based frame model.
`timescale 1ns/1ps
module tb_image_resize_out_framer;

    localparam int DATA_W  = 24;
    localparam int FIFO_AW = 10;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CALC_CY = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic [11:0]        img_width;
    logic [10:0]        img_height;
    logic               up_flag;
    logic [3:0]         x_scale_factor;
    logic [3:0]         y_scale_factor;
    logic               valid_i;
    logic [DATA_W-1:0]  data_i;
    logic               m_tvalid;
    logic               m_tready;
    logic [DATA_W-1:0]  m_tdata;
    logic               m_tuser;
    logic               m_tlast;
    logic               frame_done;
    logic               overflow;
    logic [FIFO_AW:0]   fifo_level;

    image_resize_out_framer #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .img_width      (img_width),
        .img_height     (img_height),
        .up_flag        (up_flag),
        .x_scale_factor (x_scale_factor),
        .y_scale_factor (y_scale_factor),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tuser        (m_tuser),
        .m_tlast        (m_tlast),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pixel queue plus frame phase (0 idle, 1 dimension calc, 2 streaming, 3 done).
    logic [DATA_W-1:0] mq[$];
    bit  m_ovf;
    int  phase;
    int  calc_left;
    int  beat_idx;
    int  tlast_cnt;
    int  exp_w;
    int  exp_h;
    int  frame_no;
    int  dut_done_cnt;
    int  xe;
    int  ye;
    bit  ev;
    bit  acc;
    int  rdy_mode;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            phase     = 0;
            calc_left = 0;
            beat_idx  = 0;
            tlast_cnt = 0;
        end else begin
            ev = (phase == 2) && (mq.size() > 0);
            check("fifo_level", 32'(fifo_level), mq.size());
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_done", 32'(frame_done), 32'(phase == 3));
            check("m_tvalid", 32'(m_tvalid), 32'(ev));
            if (frame_done) dut_done_cnt++;
            if (ev) begin
                check("m_tdata", 32'(m_tdata), 32'(mq[0]));
                check("m_tuser", 32'(m_tuser), 32'(beat_idx == 0));
                check("m_tlast", 32'(m_tlast), 32'((beat_idx % exp_w) == exp_w - 1));
            end
            acc = ev && m_tready;
            if (acc) begin
                void'(mq.pop_front());
                if ((beat_idx % exp_w) == exp_w - 1) tlast_cnt++;
                beat_idx++;
            end
            case (phase)
                0: if (valid_i) begin
                    xe = (x_scale_factor == 4'd0) ? 1 : int'(x_scale_factor);
                    ye = (y_scale_factor == 4'd0) ? 1 : int'(y_scale_factor);
                    if (up_flag) begin
                        exp_w = int'(img_width) * xe;
                        exp_h = int'(img_height) * ye;
                    end else begin
                        exp_w = (int'(img_width) - 1) / xe + 1;
                        exp_h = (int'(img_height) - 1) / ye + 1;
                    end
                    phase     = 1;
                    calc_left = CALC_CY;
                    beat_idx  = 0;
                    tlast_cnt = 0;
                end
                1: begin
                    calc_left--;
                    if (calc_left == 0) phase = 2;
                end
                2: if (beat_idx == exp_w * exp_h) begin
                    phase = 3;
                    check("tlast_count", tlast_cnt, exp_h);
                    frame_no++;
                    $display("frame %0d: out %0dx%0d beats=%0d tlasts=%0d", frame_no, exp_w, exp_h,
                             beat_idx, tlast_cnt);
                end
                default: phase = 0;
            endcase
            if (valid_i) begin
                if (mq.size() < DEPTH) mq.push_back(data_i);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tuser", 32'(m_tuser), 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_m_tdata", 32'(m_tdata), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        tick();
    endtask

    task automatic send_frame(input int w, input int h, input bit up, input int xs, input int ys,
                              input int npix, input bit gaps);
        img_width      = 12'(w);
        img_height     = 11'(h);
        up_flag        = up;
        x_scale_factor = 4'(xs);
        y_scale_factor = 4'(ys);
        for (int i = 0; i < npix; i++) begin
            valid_i = 1'b1;
            data_i  = DATA_W'($urandom);
            tick();
            while (gaps && ($urandom_range(0, 3) == 0)) begin
                valid_i = 1'b0;
                tick();
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(phase == 0 && mq.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; valid_i = 1'b0; data_i = '0; m_tready = 1'b1; rdy_mode = 0;
        img_width = '0; img_height = '0; up_flag = 1'b0; x_scale_factor = '0; y_scale_factor = '0;
        frame_no = 0; dut_done_cnt = 0;
        do_reset();

        send_frame(4, 2, 1'b1, 2, 3, 48, 1'b0);
        wait_idle(500);
        send_frame(10, 7, 1'b0, 3, 2, 16, 1'b0);
        wait_idle(500);
        send_frame(5, 3, 1'b1, 0, 0, 15, 1'b1);
        wait_idle(500);
        send_frame(6, 2, 1'b0, 0, 0, 12, 1'b1);
        wait_idle(500);

        rdy_mode = 1;
        send_frame(16, 16, 1'b1, 1, 1, 256, 1'b1);
        wait_idle(2000);

        rdy_mode = 2;
        m_tready = 1'b0;
        send_frame(32, 32, 1'b1, 1, 1, DEPTH + 1, 1'b0);
        tick();
        check("ovf_fifo_level", 32'(fifo_level), DEPTH);
        check("ovf_flag", 32'(overflow), 1);
        rdy_mode = 0;
        wait_idle(3000);

        rdy_mode = 0;
        send_frame(8, 4, 1'b1, 1, 1, 20, 1'b0);
        n = 0;
        while (beat_idx < 17 && n < 100) begin
            tick();
            n++;
        end
        do_reset();
        send_frame(10, 7, 1'b0, 3, 2, 16, 1'b0);
        wait_idle(500);

        check("frame_done_pulses", dut_done_cnt, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
